// File: rtl/reg_fifo_pkg.sv
// Shared width helpers and the legality check for the register FIFO depth.
// Everything here is a constant function, so it is usable in parameter expressions.
package reg_fifo_pkg;

  // Bits needed to index DEPTH entries; a pointer wraps naturally at DEPTH.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so the occupancy can represent the full value DEPTH.
  function automatic int cnt_width(input int depth);
    return ptr_width(depth) + 1;
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/reg_fifo_reg_we.sv
// Parametrised register with write enable and asynchronous active-low reset.
// Used for every storage entry, both pointers and the occupancy count.
module reg_we #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_aL,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      q <= RST_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_fifo.sv
// First-word-fall-through register FIFO: count-based full/empty, flush overrides
// enq/deq, and no enq-to-deq bypass (an entry is visible one edge after it is written).
module reg_fifo
  import reg_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_aL,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [WIDTH-1:0]             enq_data,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  output logic [WIDTH-1:0]             deq_data,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int             PW       = ptr_width(DEPTH);
  localparam int             CW       = cnt_width(DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  if (!depth_legal(DEPTH) || WIDTH < 1) begin : g_bad_params
    $error("reg_fifo: DEPTH must be a power of two >= 2 and WIDTH >= 1");
  end

  logic [PW-1:0]                head, head_nxt, tail, tail_nxt;
  logic [CW-1:0]                count_nxt;
  logic                         head_we, tail_we, count_we;
  logic                         do_enq, do_deq;
  logic [DEPTH-1:0]             mem_we;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;

  // Handshake flags come from registered state only, never from the partner's valid/ready.
  assign enq_ready = (count != FULL_CNT);
  assign deq_valid = (count != '0);
  assign deq_data  = mem[head];

  assign do_enq = enq_valid && enq_ready && !flush;
  assign do_deq = deq_valid && deq_ready && !flush;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    head_nxt  = head + PW'(1);
    tail_nxt  = tail + PW'(1);
    count_nxt = count;
    head_we   = do_deq;
    tail_we   = do_enq;
    count_we  = do_enq ^ do_deq;
    if (do_enq && !do_deq) begin
      count_nxt = count + CW'(1);
    end else if (do_deq && !do_enq) begin
      count_nxt = count - CW'(1);
    end
    if (flush) begin
      head_nxt  = '0;
      tail_nxt  = '0;
      count_nxt = '0;
      head_we   = 1'b1;
      tail_we   = 1'b1;
      count_we  = 1'b1;
    end
  end

  reg_we #(.WIDTH(PW)) u_head (
    .clk(clk), .rst_aL(rst_aL), .we(head_we), .d(head_nxt), .q(head)
  );

  reg_we #(.WIDTH(PW)) u_tail (
    .clk(clk), .rst_aL(rst_aL), .we(tail_we), .d(tail_nxt), .q(tail)
  );

  reg_we #(.WIDTH(CW)) u_count (
    .clk(clk), .rst_aL(rst_aL), .we(count_we), .d(count_nxt), .q(count)
  );

  // NOTE: storage entries are reset like any other flop, so deq_data reads a
  // defined zero after reset instead of whatever the array powered up with.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign mem_we[i] = do_enq && (tail == PW'(i));

    reg_we #(.WIDTH(WIDTH)) u_entry (
      .clk(clk), .rst_aL(rst_aL), .we(mem_we[i]), .d(enq_data), .q(mem[i])
    );
  end

endmodule

// File: tb/tb_reg_fifo.sv
// Randomised and directed checks of reg_fifo (WIDTH=8, DEPTH=4) against a queue model.
module tb_reg_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_aL;
  logic             flush;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_data;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_data;
  logic [2:0]       count;

  int vectors;
  int miscompares;
  logic [WIDTH-1:0] model_q[$];

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_aL(rst_aL), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_data(deq_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model; deq_data is only meaningful when an entry is held.
  task automatic check_outputs(input string tag);
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".enq_ready"}, 32'(enq_ready), 32'(model_q.size() != DEPTH));
    check({tag, ".deq_valid"}, 32'(deq_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) check({tag, ".deq_data"}, 32'(deq_data), 32'(model_q[0]));
  endtask

  // One clock cycle: drive at the falling edge, check, then apply the FIFO rules at the rising edge.
  task automatic step(input string tag, input logic ev, input logic [WIDTH-1:0] d,
                      input logic dr, input logic fl);
    bit take_enq, take_deq;
    @(negedge clk);
    enq_valid = ev;
    enq_data  = d;
    deq_ready = dr;
    flush     = fl;
    check_outputs(tag);
    take_enq = ev && (model_q.size() < DEPTH) && !fl;
    take_deq = dr && (model_q.size() > 0) && !fl;
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (take_deq) void'(model_q.pop_front());
      if (take_enq) model_q.push_back(d);
    end
    #1;
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_aL      = 1'b0;
    flush       = 1'b0;
    enq_valid   = 1'b0;
    enq_data    = '0;
    deq_ready   = 1'b0;
    #12;
    check("reset.count", 32'(count), 32'd0);
    check("reset.enq_ready", 32'(enq_ready), 32'd1);
    check("reset.deq_valid", 32'(deq_valid), 32'd0);
    check("reset.deq_data", 32'(deq_data), 32'd0);
    @(negedge clk);
    rst_aL = 1'b1;

    // Reset mid-fill: three entries, then an asynchronous reset between edges.
    step("mid0", 1'b1, 8'hC1, 1'b0, 1'b0);
    step("mid1", 1'b1, 8'hC2, 1'b0, 1'b0);
    step("mid2", 1'b1, 8'hC3, 1'b0, 1'b0);
    @(negedge clk);
    check("mid.count_before", 32'(count), 32'd3);
    #2 rst_aL = 1'b0;
    #1;
    check("midrst.count", 32'(count), 32'd0);
    check("midrst.deq_valid", 32'(deq_valid), 32'd0);
    check("midrst.deq_data", 32'(deq_data), 32'd0);
    check("midrst.enq_ready", 32'(enq_ready), 32'd1);
    model_q.delete();
    @(negedge clk);
    rst_aL = 1'b1;

    // Fill to full, attempt a fifth enqueue, then drain.
    step("fill0", 1'b1, 8'h11, 1'b0, 1'b0);
    step("fill1", 1'b1, 8'h22, 1'b0, 1'b0);
    step("fill2", 1'b1, 8'h33, 1'b0, 1'b0);
    step("fill3", 1'b1, 8'h44, 1'b0, 1'b0);
    step("over",  1'b1, 8'h55, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("drained", 1'b0, 8'h00, 1'b0, 1'b0);

    // Full with simultaneous enq and deq: only the dequeue happens.
    for (int i = 0; i < 4; i++) step("refill", 1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
    step("full_both", 1'b1, 8'h55, 1'b1, 1'b0);
    @(negedge clk);
    check("full_both.count", 32'(count), 32'd3);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap: steady enq+deq at occupancy two for ten cycles.
    step("wrap_pre0", 1'b1, 8'h80, 1'b0, 1'b0);
    step("wrap_pre1", 1'b1, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("wrap", 1'b1, 8'(8'h82 + i), 1'b1, 1'b0);
    @(negedge clk);
    check("wrap.count", 32'(count), 32'd2);

    // Flush overrides enq and deq; the next entry appears one edge after it is written.
    step("flush", 1'b1, 8'hEE, 1'b1, 1'b1);
    @(negedge clk);
    check("flush.count", 32'(count), 32'd0);
    check("flush.deq_valid", 32'(deq_valid), 32'd0);
    step("post_flush", 1'b1, 8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    check("post_flush.deq_data", 32'(deq_data), 32'hA5);
    step("post_flush_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Empty: dequeue requests are ignored and the pointers stay put.
    for (int i = 0; i < 3; i++) step("empty_deq", 1'b0, 8'h00, 1'b1, 1'b0);
    step("empty_enq", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("empty_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 49) == 0));
    end
    step("final", 1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_fifo.md
REG_FIFO -- requirements
Module: reg_fifo

Interface
REQ-001 Parameter WIDTH, default 32, data bits per entry (>=1).
REQ-002 Parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_aL  input  1  reset, asynchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all entries.
REQ-006 enq_valid  input  1  producer offers enq_data this cycle.
REQ-007 enq_ready  output  1  FIFO accepts an entry this cycle.
REQ-008 enq_data  input  WIDTH  entry to write.
REQ-009 deq_valid  output  1  head entry present on deq_data.
REQ-010 deq_ready  input  1  consumer takes head entry this cycle.
REQ-011 deq_data  output  WIDTH  head entry.
REQ-012 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-013 Enqueue SHALL occur on a rising edge iff enq_valid && enq_ready && !flush; data written at tail, tail pointer +1.
REQ-014 Dequeue SHALL occur on a rising edge iff deq_valid && deq_ready && !flush; head pointer +1.
REQ-015 enq_ready SHALL equal (count != DEPTH), combinational from state only, never from enq_valid/deq_ready.
REQ-016 deq_valid SHALL equal (count != 0), combinational from state only.
REQ-017 deq_data SHALL equal storage[head] combinationally (first-word-fall-through), stable while head unchanged.
REQ-018 Latency: entry enqueued at edge N SHALL appear with deq_valid high after edge N when FIFO was empty; no same-cycle enq-to-deq bypass.
REQ-019 Full: enq_ready low; simultaneous deq SHALL NOT allow enqueue that cycle (no pass-through when full).
REQ-020 Empty: deq_valid low; deq_ready ignored.
REQ-021 Simultaneous enq and deq with 0<count<DEPTH: both SHALL occur, count unchanged.
REQ-022 count SHALL be +1 on enq-only, -1 on deq-only, unchanged otherwise; never exceeds DEPTH or wraps below 0.
REQ-023 Pointers $clog2(DEPTH) bits SHALL wrap DEPTH-1 -> 0 without gap; full/empty determined by count, not pointer compare.
REQ-024 Order SHALL be strict FIFO across any number of wraps.
REQ-025 flush high at an edge SHALL set head=tail=count=0, overriding enq/deq that cycle; storage contents unchanged.
REQ-026 Storage entry written only at an enqueue edge; all other entries hold (write-enable per entry, recirculating hold).

Reset
REQ-027 rst_aL low SHALL immediately, independent of clk, force head=0, tail=0, count=0, every storage entry=0.
REQ-028 During and after reset: enq_ready=1, deq_valid=0, deq_data=0, count=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; first edge after deassertion behaves as empty FIFO.
REQ-030 Every flop in the block, including every storage bit, SHALL be reset; no unreset state.

Structure
REQ-031 Sub-module reg_we: WIDTH-parametrised register, ports clk, rst_aL, we, d, q, async active-low reset to parameter RST_VAL (default 0), hold when we=0; used for storage entries, pointers and count.
REQ-032 Shared package holds pointer/count width computation helpers and the DEPTH power-of-two legality check; no FIFO-specific typedefs elsewhere.
REQ-033 Elaboration SHALL fail for non-power-of-two DEPTH or DEPTH<2.

Verification (WIDTH=8, DEPTH=4)
REQ-034 Reset mid-fill: 3 enqueued, pulse rst_aL low between edges -> count=0, deq_valid=0, deq_data=0 before next edge; reg_we reset checked asynchronously.
REQ-035 Fill: enq 0x11,0x22,0x33,0x44 -> count=4, enq_ready=0; 5th enq 0x55 ignored; drain yields 11,22,33,44 then deq_valid=0.
REQ-036 Full + simultaneous: full, enq_valid and deq_ready high -> one deq only, count=3, 0x55 not stored.
REQ-037 Wrap: 10 cycles continuous enq/deq at count=2 with incrementing data -> output sequence strictly ordered, count stays 2.
REQ-038 Flush priority: count=2, flush with enq_valid and deq_ready high -> count=0, deq_valid=0 next cycle; next enq 0xA5 appears at deq_data one edge later.
REQ-039 Empty: deq_ready high with count=0 for 3 cycles -> count stays 0, no pointer movement.
